// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART/ALU sequencing stage, the ALU and the benches.
package uart_alu_defs;

    localparam int unsigned DEF_NB_DATA   = 8;
    localparam int unsigned DEF_NB_OPCODE = 6;

    // Sequencer states: three byte captures, one result-load cycle, transmit wait
    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_LOAD    = 3'd3,
        ST_WAIT_TX = 3'd4
    } state_e;

    // ALU opcodes (low 6 bits of the third received byte)
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode from the UART receiver, holds them
// for the external ALU, then latches the result and requests transmission.
module uart_alu_interface
    import uart_alu_defs::*;
#(
    parameter int unsigned NB_DATA   = DEF_NB_DATA,
    parameter int unsigned NB_OPCODE = DEF_NB_OPCODE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_rx_done,
    input  logic [NB_DATA-1:0]   i_alu_result,
    input  logic                 i_tx_done,
    output logic [NB_DATA-1:0]   o_data_a,
    output logic [NB_DATA-1:0]   o_data_b,
    output logic [NB_OPCODE-1:0] o_opcode,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_busy,
    output logic                 o_overrun
);

    state_e               state_q, state_d;
    logic [NB_DATA-1:0]   data_a_q, data_a_d;
    logic [NB_DATA-1:0]   data_b_q, data_b_d;
    logic [NB_OPCODE-1:0] opcode_q, opcode_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;

    // State and output registers; reset discards any partial operation
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_WAIT_A;
            data_a_q   <= '0;
            data_b_q   <= '0;
            opcode_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            opcode_q   <= opcode_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d    = state_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        opcode_d   = opcode_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        overrun_d  = overrun_q;

        unique case (state_q)
            ST_WAIT_A: begin
                if (i_rx_done) begin
                    data_a_d  = i_rx_data;
                    overrun_d = 1'b0;
                    state_d   = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (i_rx_done) begin
                    data_b_d = i_rx_data;
                    state_d  = ST_WAIT_OP;
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done) begin
                    // Upper byte bits are silently dropped
                    opcode_d = i_rx_data[NB_OPCODE-1:0];
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // ALU has had the full previous cycle to settle from opcode_q
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                state_d    = ST_WAIT_TX;
                if (i_rx_done) begin
                    overrun_d = 1'b1;
                end
            end
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = ST_WAIT_A;
                end
                if (i_rx_done) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase

        busy_d = (state_d == ST_LOAD) || (state_d == ST_WAIT_TX);
    end

    assign o_data_a   = data_a_q;
    assign o_data_b   = data_b_q;
    assign o_opcode   = opcode_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: directed scenarios plus randomized operations
// checked against a byte-level model of the expected sequencing.
module tb_uart_alu_interface;
    import uart_alu_defs::*;

    localparam int unsigned NBD = 8;
    localparam int unsigned NBO = 6;

    logic           clock;
    logic           reset;
    logic [NBD-1:0] i_rx_data;
    logic           i_rx_done;
    logic [NBD-1:0] i_alu_result;
    logic           i_tx_done;
    logic [NBD-1:0] o_data_a;
    logic [NBD-1:0] o_data_b;
    logic [NBO-1:0] o_opcode;
    logic [NBD-1:0] o_tx_data;
    logic           o_tx_start;
    logic           o_busy;
    logic           o_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    uart_alu_interface #(.NB_DATA(NBD), .NB_OPCODE(NBO)) dut (
        .clock       (clock),
        .reset       (reset),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .i_alu_result(i_alu_result),
        .i_tx_done   (i_tx_done),
        .o_data_a    (o_data_a),
        .o_data_b    (o_data_b),
        .o_opcode    (o_opcode),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference ALU, also used as the external ALU driving i_alu_result
    function automatic logic [NBD-1:0] alu_ref(input logic [NBD-1:0] a,
                                               input logic [NBD-1:0] b,
                                               input logic [NBO-1:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRA:  return NBD'($signed(a) >>> b);
            OP_SRL:  return a >> b;
            default: return '0;
        endcase
    endfunction

    always_comb i_alu_result = alu_ref(o_data_a, o_data_b, o_opcode);

    // One received byte: pulse is high across exactly one rising edge
    task automatic send_byte(input logic [NBD-1:0] b);
        @(negedge clock);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clock);
        i_rx_done = 1'b0;
        i_rx_data = '0;
    endtask

    task automatic pulse_tx_done();
        @(negedge clock);
        i_tx_done = 1'b1;
        @(negedge clock);
        i_tx_done = 1'b0;
    endtask

    // Sends opcode byte and checks the LOAD / start-pulse timing and result
    task automatic finish_op(input string name, input logic [NBD-1:0] op_byte,
                             input logic [NBD-1:0] exp_res);
        send_byte(op_byte);
        // cycle n+1: in LOAD
        n_checks++;
        if (o_opcode !== op_byte[NBO-1:0] || o_busy !== 1'b1 || o_tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL %s load: opcode=%h busy=%b start=%b, required opcode=%h busy=1 start=0",
                     name, o_opcode, o_busy, o_tx_start, op_byte[NBO-1:0]);
        end
        @(negedge clock);
        // cycle n+2: start pulse with result
        n_checks++;
        if (o_tx_start !== 1'b1 || o_tx_data !== exp_res) begin
            n_fail++;
            $display("FAIL %s start: start=%b tx_data=%h, required start=1 tx_data=%h",
                     name, o_tx_start, o_tx_data, exp_res);
        end
        @(negedge clock);
        n_checks++;
        if (o_tx_start !== 1'b0 || o_busy !== 1'b1 || o_tx_data !== exp_res) begin
            n_fail++;
            $display("FAIL %s after_start: start=%b busy=%b tx_data=%h, required start=0 busy=1 tx_data=%h",
                     name, o_tx_start, o_busy, o_tx_data, exp_res);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; i_rx_data = '0; i_rx_done = 1'b0; i_tx_done = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({o_data_a, o_data_b, o_opcode, o_tx_data, o_tx_start, o_busy, o_overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: a=%h b=%h op=%h tx=%h start=%b busy=%b ovr=%b, required all 0",
                     o_data_a, o_data_b, o_opcode, o_tx_data, o_tx_start, o_busy, o_overrun);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_add();
        send_byte(8'h03);
        send_byte(8'h03);
        n_checks++;
        if (o_data_a !== 8'h03 || o_data_b !== 8'h03 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL add_operands: a=%h b=%h busy=%b, required a=03 b=03 busy=0",
                     o_data_a, o_data_b, o_busy);
        end
        finish_op("add", 8'h20, 8'h06);
        // no second start pulse while waiting
        repeat (4) begin
            @(negedge clock);
            n_checks++;
            if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL add_wait: start=%b busy=%b, required start=0 busy=1", o_tx_start, o_busy);
            end
        end
        pulse_tx_done();
    endtask

    task automatic test_sub_return();
        send_byte(8'h05);
        send_byte(8'h07);
        finish_op("sub", 8'h22, 8'hFE);
        pulse_tx_done();
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_return_busy: busy=%b, required 0", o_busy);
        end
        // back in WAIT_A: next byte lands in operand A
        send_byte(8'hA1);
        n_checks++;
        if (o_data_a !== 8'hA1 || o_data_b !== 8'h07) begin
            n_fail++;
            $display("FAIL sub_return_state: a=%h b=%h, required a=a1 b=07", o_data_a, o_data_b);
        end
        send_byte(8'h0F);
        finish_op("xor", 8'h26, 8'hAE);
        pulse_tx_done();
    endtask

    task automatic test_overrun();
        send_byte(8'h11);
        send_byte(8'h22);
        finish_op("ovr_op", 8'h20, 8'h33);
        send_byte(8'h55);
        n_checks++;
        if (o_overrun !== 1'b1 || o_data_a !== 8'h11 || o_data_b !== 8'h22 || o_opcode !== 6'h20) begin
            n_fail++;
            $display("FAIL overrun_set: ovr=%b a=%h b=%h op=%h, required ovr=1 a=11 b=22 op=20",
                     o_overrun, o_data_a, o_data_b, o_opcode);
        end
        repeat (3) begin
            @(negedge clock);
            n_checks++;
            if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL overrun_no_restart: start=%b busy=%b, required start=0 busy=1",
                         o_tx_start, o_busy);
            end
        end
        pulse_tx_done();
        n_checks++;
        if (o_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: ovr=%b, required 1", o_overrun);
        end
        send_byte(8'h44);
        n_checks++;
        if (o_overrun !== 1'b0 || o_data_a !== 8'h44) begin
            n_fail++;
            $display("FAIL overrun_clear: ovr=%b a=%h, required ovr=0 a=44", o_overrun, o_data_a);
        end
        send_byte(8'h0C);
        finish_op("nor", 8'h27, 8'hB3);
        pulse_tx_done();
    endtask

    task automatic test_simultaneous();
        send_byte(8'h80);
        send_byte(8'h02);
        finish_op("sra", 8'h03, 8'hE0);
        @(negedge clock);
        i_rx_data = 8'h77; i_rx_done = 1'b1; i_tx_done = 1'b1;
        @(negedge clock);
        i_rx_data = '0; i_rx_done = 1'b0; i_tx_done = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_overrun !== 1'b1 || o_data_a !== 8'h80) begin
            n_fail++;
            $display("FAIL simul: busy=%b ovr=%b a=%h, required busy=0 ovr=1 a=80",
                     o_busy, o_overrun, o_data_a);
        end
        send_byte(8'h09);
        n_checks++;
        if (o_data_a !== 8'h09 || o_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_next_a: a=%h ovr=%b, required a=09 ovr=0", o_data_a, o_overrun);
        end
        send_byte(8'h01);
        finish_op("srl", 8'h02, 8'h04);
        pulse_tx_done();
    endtask

    task automatic test_reset_mid();
        // reset while the start pulse is high
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h20);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({o_data_a, o_data_b, o_opcode, o_tx_data, o_tx_start, o_busy, o_overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_at_start: a=%h b=%h op=%h tx=%h start=%b busy=%b ovr=%b, required all 0",
                     o_data_a, o_data_b, o_opcode, o_tx_data, o_tx_start, o_busy, o_overrun);
        end
        @(negedge clock);
        reset = 1'b1;
        // reset after operand B
        send_byte(8'hC3);
        send_byte(8'h3C);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({o_data_a, o_data_b, o_opcode, o_tx_data, o_tx_start, o_busy, o_overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: a=%h b=%h op=%h tx=%h start=%b busy=%b ovr=%b, required all 0",
                     o_data_a, o_data_b, o_opcode, o_tx_data, o_tx_start, o_busy, o_overrun);
        end
        @(negedge clock);
        reset = 1'b1;
        send_byte(8'h01);
        send_byte(8'h02);
        finish_op("or_after_reset", 8'h25, 8'h03);
        pulse_tx_done();
    endtask

    task automatic test_trunc_stray();
        send_byte(8'h5A);
        pulse_tx_done();
        n_checks++;
        if (o_busy !== 1'b0 || o_data_a !== 8'h5A) begin
            n_fail++;
            $display("FAIL stray_txdone: busy=%b a=%h, required busy=0 a=5a", o_busy, o_data_a);
        end
        send_byte(8'h33);
        n_checks++;
        if (o_data_b !== 8'h33 || o_data_a !== 8'h5A) begin
            n_fail++;
            $display("FAIL stray_b_capture: a=%h b=%h, required a=5a b=33", o_data_a, o_data_b);
        end
        finish_op("and_trunc", 8'hE4, 8'h12);
        pulse_tx_done();
    endtask

    // Randomized operations with gaps and stray tx_done pulses outside WAIT_TX
    task automatic test_random();
        logic [NBO-1:0] ops [8];
        logic [NBD-1:0] a, b, opb;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
        for (int k = 0; k < 24; k++) begin
            a   = NBD'($urandom);
            b   = NBD'($urandom_range(0, 255));
            if (ops[k % 8] == OP_SRA || ops[k % 8] == OP_SRL) b = NBD'($urandom_range(0, 9));
            opb = {2'($urandom), ops[$urandom_range(0, 7)]};
            send_byte(a);
            repeat ($urandom_range(0, 3)) @(negedge clock);
            if ($urandom_range(0, 1) == 1) pulse_tx_done();
            send_byte(b);
            repeat ($urandom_range(0, 3)) @(negedge clock);
            n_checks++;
            if (o_data_a !== a || o_data_b !== b || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_operands[%0d]: a=%h b=%h busy=%b, required a=%h b=%h busy=0",
                         k, o_data_a, o_data_b, o_busy, a, b);
            end
            finish_op("rand_op", opb, alu_ref(a, b, opb[NBO-1:0]));
            repeat ($urandom_range(0, 3)) @(negedge clock);
            pulse_tx_done();
            n_checks++;
            if (o_busy !== 1'b0 || o_overrun !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_return[%0d]: busy=%b ovr=%b, required busy=0 ovr=0",
                         k, o_busy, o_overrun);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_return();
        test_overrun();
        test_simultaneous();
        test_reset_mid();
        test_trunc_stray();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
